// File: rtl/jtcontra_gfx_rom_arb.sv
// ---------------------------------------------------------------------------
// jtcontra_gfx_rom_arb
//
// Shares one SDRAM graphics-ROM slot between the two fetch engines of the
// 007121 graphics unit: requester 0 is the tile/scroll scanner and
// requester 1 is the object line drawer. A requester holds reqN_cs high
// until it sees reqN_ok. The arbiter then does the following:
//   - latches the winner's address;
//   - drives the ROM slot;
//   - skips one settle cycle, because rom_ok may still describe the
//     previous address;
//   - waits for rom_ok;
//   - returns the word with a one-cycle ok pulse.
//
// Ports
//   clk24               clock, all logic on the rising edge
//   rst                 synchronous active-high reset
//   req0_cs/req0_addr   requester 0 request and word address
//   req0_data/req0_ok   requester 0 data and one-cycle valid pulse
//   req1_cs/req1_addr   requester 1 request and word address
//   req1_data/req1_ok   requester 1 data and one-cycle valid pulse
//   rom_addr/rom_cs     SDRAM slot address and request (registered)
//   rom_data/rom_ok     SDRAM slot data and level valid
//   busy                high whenever the arbiter is not idle
// ---------------------------------------------------------------------------
module jtcontra_gfx_rom_arb #(
    parameter int AW         = 18,
    parameter int DW         = 16,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic          clk24,
    input  logic          rst,
    input  logic          req0_cs,
    input  logic [AW-1:0] req0_addr,
    output logic [DW-1:0] req0_data,
    output logic          req0_ok,
    input  logic          req1_cs,
    input  logic [AW-1:0] req1_addr,
    output logic [DW-1:0] req1_data,
    output logic          req1_ok,
    output logic [AW-1:0] rom_addr,
    output logic          rom_cs,
    input  logic [DW-1:0] rom_data,
    input  logic          rom_ok,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          gnt_q, gnt_d;      // requester owning the current transfer
    logic          last_q, last_d;    // requester granted most recently
    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic          rom_cs_q, rom_cs_d;
    logic [DW-1:0] req0_data_q, req0_data_d;
    logic [DW-1:0] req1_data_q, req1_data_d;
    logic          req0_ok_q, req0_ok_d;
    logic          req1_ok_q, req1_ok_d;
    logic          busy_q;

    logic          gnt_cs_s;          // cs of the requester currently granted
    logic          pick_s;            // winner if a grant happens in IDLE

    // Next-state and output decode for the grant/transfer sequencer
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        rom_addr_d  = rom_addr_q;
        rom_cs_d    = rom_cs_q;
        req0_data_d = req0_data_q;
        req1_data_d = req1_data_q;
        req0_ok_d   = 1'b0;            // ok is only ever a single-cycle pulse
        req1_ok_d   = 1'b0;
        gnt_cs_s    = gnt_q ? req1_cs : req0_cs;
        pick_s      = 1'b0;

        // On a tie, round-robin hands the slot to whoever was not served last
        if (req0_cs && req1_cs) begin
            pick_s = FIXED_PRIO ? 1'b0 : ~last_q;
        end else if (req1_cs) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (req0_cs || req1_cs) begin
                    gnt_d      = pick_s;
                    last_d     = pick_s;
                    rom_addr_d = pick_s ? req1_addr : req0_addr;
                    rom_cs_d   = 1'b1;
                    state_d    = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            // rom_ok may still refer to the previous address here: ignore it
            ST_SETTLE: begin
                if (!gnt_cs_s) begin
                    rom_cs_d = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!gnt_cs_s) begin
                    // Requester withdrew: drop the slot without an ok pulse
                    rom_cs_d = 1'b0;
                    state_d  = ST_IDLE;
                end else if (rom_ok) begin
                    if (gnt_q) begin
                        req1_data_d = rom_data;
                        req1_ok_d   = 1'b1;
                    end else begin
                        req0_data_d = rom_data;
                        req0_ok_d   = 1'b1;
                    end
                    rom_cs_d = 1'b0;
                    state_d  = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            // ok pulse is visible for this one cycle; requester drops cs now
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                rom_cs_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk24) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 1'b0;
            last_q      <= 1'b1;       // first tie after reset goes to requester 0
            rom_addr_q  <= {AW{1'b0}};
            rom_cs_q    <= 1'b0;
            req0_data_q <= {DW{1'b0}};
            req1_data_q <= {DW{1'b0}};
            req0_ok_q   <= 1'b0;
            req1_ok_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            rom_addr_q  <= rom_addr_d;
            rom_cs_q    <= rom_cs_d;
            req0_data_q <= req0_data_d;
            req1_data_q <= req1_data_d;
            req0_ok_q   <= req0_ok_d;
            req1_ok_q   <= req1_ok_d;
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign rom_addr  = rom_addr_q;
    assign rom_cs    = rom_cs_q;
    assign req0_data = req0_data_q;
    assign req1_data = req1_data_q;
    assign req0_ok   = req0_ok_q;
    assign req1_ok   = req1_ok_q;
    assign busy      = busy_q;

endmodule
